// File: rtl/spec_rat_ckpt.sv
// Speculative register alias table with a circular queue of map checkpoints.
// Rename reads are combinational with intra-group bypass. The map is updated
// each cycle from one source: checkpoint restore, ROB rollback, ROB walk or
// IDLE rename writes.
module spec_rat_ckpt #(
    parameter int RN_WIDTH = 2,
    parameter int LREG_W   = 5,
    parameter int PREG_W   = 6,
    parameter int NUM_CKPT = 4,
    localparam int NUM_LREG = 2 ** LREG_W,
    localparam int CKPT_W   = $clog2(NUM_CKPT),
    localparam int SLOT_W   = (RN_WIDTH > 1) ? $clog2(RN_WIDTH) : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [RN_WIDTH-1:0]          rn_wren,
    input  logic [RN_WIDTH*LREG_W-1:0]   rn_wraddr,
    input  logic [RN_WIDTH*PREG_W-1:0]   rn_wrdata,
    input  logic [RN_WIDTH-1:0]          rn_rs1_rden,
    input  logic [RN_WIDTH-1:0]          rn_rs2_rden,
    input  logic [RN_WIDTH-1:0]          rn_rd_rden,
    input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs1,
    input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrs2,
    input  logic [RN_WIDTH*LREG_W-1:0]   rn_lrd,
    output logic [RN_WIDTH*PREG_W-1:0]   rn_prs1,
    output logic [RN_WIDTH*PREG_W-1:0]   rn_prs2,
    output logic [RN_WIDTH*PREG_W-1:0]   rn_old_prd,
    input  logic [1:0]                   rob_state,
    input  logic [RN_WIDTH-1:0]          walk_valid,
    input  logic [RN_WIDTH*LREG_W-1:0]   walk_lrd,
    input  logic [RN_WIDTH*PREG_W-1:0]   walk_prd,
    input  logic [NUM_LREG*PREG_W-1:0]   arch_map,
    input  logic                         ckpt_alloc,
    input  logic [SLOT_W-1:0]            ckpt_alloc_slot,
    output logic [CKPT_W-1:0]            ckpt_alloc_id,
    output logic                         ckpt_full,
    output logic [CKPT_W:0]              ckpt_count,
    input  logic                         ckpt_free,
    input  logic                         ckpt_restore,
    input  logic [CKPT_W-1:0]            ckpt_restore_id
);

    localparam logic [1:0] ROB_STATE_IDLE     = 2'd0;
    localparam logic [1:0] ROB_STATE_ROLLBACK = 2'd1;
    localparam logic [1:0] ROB_STATE_WALK     = 2'd2;

    logic [PREG_W-1:0] map_q  [NUM_LREG];
    logic [PREG_W-1:0] map_d  [NUM_LREG];
    logic [PREG_W-1:0] snap_q [NUM_CKPT][NUM_LREG];
    logic [PREG_W-1:0] snap_d [NUM_LREG];

    logic [CKPT_W-1:0] head_q, head_d;
    logic [CKPT_W-1:0] tail_q, tail_d;
    logic [CKPT_W:0]   count_q, count_d;
    logic              full_q, full_d;

    logic [CKPT_W-1:0] restore_off;
    logic              restore_live;
    logic              alloc_ok;
    logic              free_ok;

    assign ckpt_alloc_id = tail_q;
    assign ckpt_full     = full_q;
    assign ckpt_count    = count_q;

    // Map lookup for one slot, bypassing the youngest older-slot write to the same register.
    function automatic logic [PREG_W-1:0] lookup(input logic [LREG_W-1:0] addr, input int slot);
        logic [PREG_W-1:0] val;
        val = map_q[addr];
        for (int j = 0; j < RN_WIDTH; j++) begin
            if (j < slot && rn_wren[j] && rn_wraddr[j*LREG_W +: LREG_W] == addr) begin
                val = rn_wrdata[j*PREG_W +: PREG_W];
            end
        end
        return val;
    endfunction

    // Combinational per-slot source/destination reads; a disabled read returns zero.
    always_comb begin
        rn_prs1    = '0;
        rn_prs2    = '0;
        rn_old_prd = '0;
        for (int k = 0; k < RN_WIDTH; k++) begin
            if (rn_rs1_rden[k]) rn_prs1[k*PREG_W +: PREG_W]    = lookup(rn_lrs1[k*LREG_W +: LREG_W], k);
            if (rn_rs2_rden[k]) rn_prs2[k*PREG_W +: PREG_W]    = lookup(rn_lrs2[k*LREG_W +: LREG_W], k);
            if (rn_rd_rden[k])  rn_old_prd[k*PREG_W +: PREG_W] = lookup(rn_lrd[k*LREG_W +: LREG_W], k);
        end
    end

    // Checkpoint queue control: a restore to a live id truncates the queue after it.
    always_comb begin
        restore_off  = ckpt_restore_id - head_q;
        restore_live = ckpt_restore && ({1'b0, restore_off} < count_q);
        alloc_ok     = ckpt_alloc && !full_q && !ckpt_restore;
        free_ok      = ckpt_free && (count_q != '0) && !ckpt_restore;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        if (restore_live) begin
            tail_d  = ckpt_restore_id + 1'b1;
            count_d = {1'b0, restore_off} + 1'b1;
        end else begin
            if (alloc_ok) tail_d = tail_q + 1'b1;
            if (free_ok)  head_d = head_q + 1'b1;
            if (alloc_ok && !free_ok) count_d = count_q + 1'b1;
            if (free_ok && !alloc_ok) count_d = count_q - 1'b1;
        end
        full_d = (count_d == (CKPT_W+1)'(NUM_CKPT));
    end

    // Next map from the single winning update source, plus the snapshot image for an alloc.
    always_comb begin
        map_d  = map_q;
        snap_d = map_q;
        if (restore_live) begin
            map_d = snap_q[ckpt_restore_id];
        end else if (rob_state == ROB_STATE_ROLLBACK) begin
            for (int i = 0; i < NUM_LREG; i++) begin
                map_d[i] = arch_map[i*PREG_W +: PREG_W];
            end
        end else if (rob_state == ROB_STATE_WALK) begin
            for (int p = 0; p < RN_WIDTH; p++) begin
                if (walk_valid[p]) map_d[walk_lrd[p*LREG_W +: LREG_W]] = walk_prd[p*PREG_W +: PREG_W];
            end
        end else if (rob_state == ROB_STATE_IDLE) begin
            for (int p = 0; p < RN_WIDTH; p++) begin
                if (rn_wren[p]) map_d[rn_wraddr[p*LREG_W +: LREG_W]] = rn_wrdata[p*PREG_W +: PREG_W];
                if (SLOT_W'(p) == ckpt_alloc_slot) snap_d = map_d;
            end
        end
    end

    // Map and queue registers; reset restores the identity mapping and an empty queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LREG; i++) begin
                map_q[i] <= PREG_W'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            map_q   <= map_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Snapshot storage holds no meaningful value until allocated, so it has no reset.
    always_ff @(posedge clock) begin
        if (alloc_ok) snap_q[tail_q] <= snap_d;
    end

endmodule

// File: tb/tb_spec_rat_ckpt.sv
// Self-checking bench for spec_rat_ckpt: table-driven read/bypass vectors
// followed by directed checkpoint, restore, priority, walk and reset sequences.
module tb_spec_rat_ckpt;

    localparam int RN = 2;
    localparam int LW = 5;
    localparam int PW = 6;
    localparam int NL = 32;

    logic            clock;
    logic            reset_n;
    logic [RN-1:0]   rn_wren;
    logic [RN*LW-1:0] rn_wraddr;
    logic [RN*PW-1:0] rn_wrdata;
    logic [RN-1:0]   rn_rs1_rden, rn_rs2_rden, rn_rd_rden;
    logic [RN*LW-1:0] rn_lrs1, rn_lrs2, rn_lrd;
    logic [RN*PW-1:0] rn_prs1, rn_prs2, rn_old_prd;
    logic [1:0]      rob_state;
    logic [RN-1:0]   walk_valid;
    logic [RN*LW-1:0] walk_lrd;
    logic [RN*PW-1:0] walk_prd;
    logic [NL*PW-1:0] arch_map;
    logic            ckpt_alloc;
    logic [0:0]      ckpt_alloc_slot;
    logic [1:0]      ckpt_alloc_id;
    logic            ckpt_full;
    logic [2:0]      ckpt_count;
    logic            ckpt_free;
    logic            ckpt_restore;
    logic [1:0]      ckpt_restore_id;

    spec_rat_ckpt dut (
        .clock(clock), .reset_n(reset_n),
        .rn_wren(rn_wren), .rn_wraddr(rn_wraddr), .rn_wrdata(rn_wrdata),
        .rn_rs1_rden(rn_rs1_rden), .rn_rs2_rden(rn_rs2_rden), .rn_rd_rden(rn_rd_rden),
        .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2), .rn_lrd(rn_lrd),
        .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_old_prd(rn_old_prd),
        .rob_state(rob_state), .walk_valid(walk_valid), .walk_lrd(walk_lrd), .walk_prd(walk_prd),
        .arch_map(arch_map),
        .ckpt_alloc(ckpt_alloc), .ckpt_alloc_slot(ckpt_alloc_slot), .ckpt_alloc_id(ckpt_alloc_id),
        .ckpt_full(ckpt_full), .ckpt_count(ckpt_count), .ckpt_free(ckpt_free),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int wren, wa0, wd0, wa1, wd1, rden;
        int rs1_0, rs1_1, rs2_0, rs2_1, rd_0, rd_1;
        int e_prs1_0, e_prs1_1, e_prs2_0, e_prs2_1, e_old_0, e_old_1;
    } vec_t;

    typedef struct {
        string name;
        int    exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    vec_t     vecs[5];
    int       n_checks = 0;
    int       n_fails  = 0;
    int       v;

    task automatic push_exp(input string name, input int exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic check_output(input int act);
        sb_item_t it;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fails++;
            $display("[TB] FAIL scoreboard_empty got %0d", act);
        end else begin
            it = sb_q.pop_front();
            if (act !== it.exp) begin
                n_fails++;
                $display("[TB] FAIL %s got %0d expected %0d", it.name, act, it.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        rn_wren = '0; rn_wraddr = '0; rn_wrdata = '0;
        rn_rs1_rden = '0; rn_rs2_rden = '0; rn_rd_rden = '0;
        rn_lrs1 = '0; rn_lrs2 = '0; rn_lrd = '0;
        rob_state = 2'd0; walk_valid = '0; walk_lrd = '0; walk_prd = '0;
        ckpt_alloc = 1'b0; ckpt_alloc_slot = '0; ckpt_free = 1'b0;
        ckpt_restore = 1'b0; ckpt_restore_id = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        #12;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic read_map(input int x, output int val);
        @(negedge clock);
        rn_lrs1     = {5'd0, 5'(x)};
        rn_rs1_rden = 2'b01;
        #1;
        val = int'(rn_prs1[PW-1:0]);
        rn_rs1_rden = '0;
    endtask

    task automatic write_two(input int wren, input int a0, input int d0, input int a1, input int d1);
        rn_wren   = 2'(wren);
        rn_wraddr = {5'(a1), 5'(a0)};
        rn_wrdata = {6'(d1), 6'(d0)};
    endtask

    task automatic check_queue_state(input string tag, input int cnt, input int full, input int id);
        push_exp({tag, "_count"}, cnt);
        push_exp({tag, "_full"}, full);
        push_exp({tag, "_alloc_id"}, id);
        check_output(int'(ckpt_count));
        check_output(int'(ckpt_full));
        check_output(int'(ckpt_alloc_id));
    endtask

    task automatic apply_stimulus(input vec_t t, input int idx);
        @(negedge clock);
        write_two(t.wren, t.wa0, t.wd0, t.wa1, t.wd1);
        rn_rs1_rden = 2'(t.rden); rn_rs2_rden = 2'(t.rden); rn_rd_rden = 2'(t.rden);
        rn_lrs1 = {5'(t.rs1_1), 5'(t.rs1_0)};
        rn_lrs2 = {5'(t.rs2_1), 5'(t.rs2_0)};
        rn_lrd  = {5'(t.rd_1), 5'(t.rd_0)};
        push_exp($sformatf("vec%0d_prs1_s0", idx), t.e_prs1_0);
        push_exp($sformatf("vec%0d_prs1_s1", idx), t.e_prs1_1);
        push_exp($sformatf("vec%0d_prs2_s0", idx), t.e_prs2_0);
        push_exp($sformatf("vec%0d_prs2_s1", idx), t.e_prs2_1);
        push_exp($sformatf("vec%0d_oldprd_s0", idx), t.e_old_0);
        push_exp($sformatf("vec%0d_oldprd_s1", idx), t.e_old_1);
        #1;
        check_output(int'(rn_prs1[5:0]));
        check_output(int'(rn_prs1[11:6]));
        check_output(int'(rn_prs2[5:0]));
        check_output(int'(rn_prs2[11:6]));
        check_output(int'(rn_old_prd[5:0]));
        check_output(int'(rn_old_prd[11:6]));
        #1;
        idle_inputs();
    endtask

    initial begin
        arch_map = '0;
        idle_inputs();
        // wren wa0 wd0 wa1 wd1 rden | rs1 s0,s1 rs2 s0,s1 rd s0,s1 | expected prs1, prs2, old_prd
        vecs[0] = '{0, 0, 0, 0, 0, 3,  1, 2,  3, 4,  5, 6,   1, 2,  3, 4,   5, 6};
        vecs[1] = '{3, 5, 40, 5, 41, 3, 5, 5,  9, 5,  5, 5,   5, 40, 9, 40,  5, 40};
        vecs[2] = '{0, 0, 0, 0, 0, 0,  7, 8,  9, 10, 11, 12, 0, 0,  0, 0,   0, 0};
        vecs[3] = '{2, 0, 0, 12, 63, 2, 1, 12, 2, 12, 3, 12,  0, 12, 0, 12,  0, 12};
        vecs[4] = '{1, 3, 60, 0, 0, 3, 3, 4,  2, 3,  3, 3,   3, 4,  2, 60,  3, 60};

        apply_reset();
        check_queue_state("reset", 0, 0, 0);
        push_exp("reset_map7", 7);   read_map(7, v);  check_output(v);
        push_exp("reset_map31", 31); read_map(31, v); check_output(v);

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i], i);

        // Same-cycle bypass group becomes architectural map the next cycle.
        @(negedge clock);
        write_two(3, 5, 40, 5, 41);
        push_exp("bypass_next_x5", 41);
        tick();
        read_map(5, v); check_output(v);

        // Checkpoint after slot 0, later overwrite, then restore id 0.
        apply_reset();
        write_two(3, 3, 33, 4, 44);
        ckpt_alloc = 1'b1; ckpt_alloc_slot = 1'b0;
        tick();
        check_queue_state("ckpt_alloc", 1, 0, 1);
        write_two(1, 3, 50, 0, 0);
        tick();
        push_exp("pre_restore_x3", 50); read_map(3, v); check_output(v);
        push_exp("pre_restore_x4", 44); read_map(4, v); check_output(v);
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
        tick();
        push_exp("restore_x3", 33); read_map(3, v); check_output(v);
        push_exp("restore_x4", 4);  read_map(4, v); check_output(v);
        check_queue_state("restore", 1, 0, 1);

        // Fill the queue, drop an alloc that coincides with a free, then wrap.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("fill_id%0d", i), i);
            check_output(int'(ckpt_alloc_id));
            ckpt_alloc = 1'b1;
            tick();
        end
        check_queue_state("full", 4, 1, 0);
        ckpt_alloc = 1'b1; ckpt_free = 1'b1;
        tick();
        check_queue_state("full_drop", 3, 0, 0);
        ckpt_alloc = 1'b1;
        tick();
        check_queue_state("wrap", 4, 1, 1);

        // Live restore outranks rollback and rename in the same cycle.
        apply_reset();
        write_two(1, 10, 50, 0, 0);
        ckpt_alloc = 1'b1;
        tick();
        write_two(1, 10, 51, 0, 0);
        tick();
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
        rob_state = 2'd1;
        for (int i = 0; i < NL; i++) arch_map[i*PW +: PW] = 6'd62;
        write_two(1, 11, 52, 0, 0);
        tick();
        push_exp("prio_x10", 50); read_map(10, v); check_output(v);
        push_exp("prio_x11", 11); read_map(11, v); check_output(v);
        push_exp("prio_x0", 0);   read_map(0, v);  check_output(v);
        check_queue_state("prio", 1, 0, 1);

        // Rollback alone copies the architectural map.
        rob_state = 2'd1;
        tick();
        push_exp("rollback_x20", 62); read_map(20, v); check_output(v);
        arch_map = '0;

        // Walk with equal lrd on both ports, rename ignored; then a non-live restore.
        apply_reset();
        rob_state = 2'd2; walk_valid = 2'b11;
        walk_lrd = {5'd7, 5'd7}; walk_prd = {6'd21, 6'd20};
        write_two(1, 8, 30, 0, 0);
        tick();
        push_exp("walk_x7", 21); read_map(7, v); check_output(v);
        push_exp("walk_x8", 8);  read_map(8, v); check_output(v);
        ckpt_alloc = 1'b1;
        tick();
        write_two(1, 7, 22, 0, 0);
        tick();
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
        tick();
        check_queue_state("nonlive", 1, 0, 1);
        push_exp("nonlive_x7", 22); read_map(7, v); check_output(v);

        // Asynchronous reset in the middle of a walk with two live checkpoints.
        apply_reset();
        write_two(1, 1, 40, 0, 0);
        ckpt_alloc = 1'b1;
        tick();
        ckpt_alloc = 1'b1;
        tick();
        check_queue_state("pre_reset", 2, 0, 2);
        rob_state = 2'd2; walk_valid = 2'b01; walk_lrd = {5'd0, 5'd2}; walk_prd = {6'd0, 6'd45};
        tick();
        rob_state = 2'd2; walk_valid = 2'b01; walk_lrd = {5'd0, 5'd2}; walk_prd = {6'd0, 6'd46};
        #2;
        reset_n = 1'b0;
        #1;
        check_queue_state("async_reset", 0, 0, 0);
        rn_lrs1 = {5'd0, 5'd1}; rn_rs1_rden = 2'b01;
        #1;
        push_exp("async_reset_x1", 1); check_output(int'(rn_prs1[5:0]));
        rn_lrs1 = {5'd0, 5'd2};
        #1;
        push_exp("async_reset_x2", 2); check_output(int'(rn_prs1[5:0]));
        @(negedge clock);
        idle_inputs();
        reset_n = 1'b1;
        write_two(1, 3, 9, 0, 0);
        tick();
        push_exp("post_reset_x3", 9); read_map(3, v); check_output(v);
        check_queue_state("post_reset", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spec_rat_ckpt.md
SPEC_RAT_CKPT -- requirements
Module: spec_rat_ckpt

Interface
REQ-001 Parameter RN_WIDTH, default 2, number of rename slots per cycle. Slot 0 is oldest.
REQ-002 Parameter LREG_W, default 5, logical register index width. NUM_LREG = 2**LREG_W.
REQ-003 Parameter PREG_W, default 6, physical register index width.
REQ-004 Parameter NUM_CKPT, default 4, checkpoint count. Power of two, at least 2. CKPT_W = clog2(NUM_CKPT).
REQ-005 clock  in  1  clock; all state updates on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 rn_wren  in  RN_WIDTH  per-slot destination-mapping write enable.
REQ-008 rn_wraddr  in  RN_WIDTH*LREG_W  per-slot logical destination.
REQ-009 rn_wrdata  in  RN_WIDTH*PREG_W  per-slot new physical destination.
REQ-010 rn_rs1_rden, rn_rs2_rden, rn_rd_rden  in  RN_WIDTH each  per-slot read enables.
REQ-011 rn_lrs1, rn_lrs2, rn_lrd  in  RN_WIDTH*LREG_W each  per-slot read addresses.
REQ-012 rn_prs1, rn_prs2, rn_old_prd  out  RN_WIDTH*PREG_W each  per-slot read data.
REQ-013 rob_state  in  2  uses the shared ROB_STATE_IDLE / ROB_STATE_ROLLBACK / ROB_STATE_WALK encodings.
REQ-014 walk_valid  in  RN_WIDTH  per-port walk valid.
REQ-015 walk_lrd  in  RN_WIDTH*LREG_W  per-port walk logical register.
REQ-016 walk_prd  in  RN_WIDTH*PREG_W  per-port walk physical register.
REQ-017 arch_map  in  NUM_LREG*PREG_W  flattened architectural RAT; entry i at bits [i*PREG_W +: PREG_W].
REQ-018 ckpt_alloc  in  1  requests a checkpoint.
REQ-019 ckpt_alloc_slot  in  clog2(RN_WIDTH) (minimum 1)  slot holding the branch being checkpointed.
REQ-020 ckpt_alloc_id  out  CKPT_W  id granted to the allocation (current tail).
REQ-021 ckpt_full  out  1  registered flag: all checkpoints in use.
REQ-022 ckpt_count  out  CKPT_W+1  registered count of live checkpoints.
REQ-023 ckpt_free  in  1  releases the oldest checkpoint (branch resolved correctly).
REQ-024 ckpt_restore  in  1  restore request (mispredict).
REQ-025 ckpt_restore_id  in  CKPT_W  checkpoint to restore.

Function
REQ-026 Reads SHALL be combinational with zero latency.
- Slot k sees the stored map, overridden by the youngest write from slots j<k with matching address.
- A slot's own write is never bypassed to itself.
- A disabled read SHALL return 0.
REQ-027 Map updates SHALL occur on the rising edge and become visible the next cycle. Exactly one update source applies per cycle, by priority:
- ckpt_restore,
- then ROLLBACK,
- then WALK,
- then IDLE rename.
REQ-028 Restore SHALL load the map from snapshot[ckpt_restore_id].
- It applies only if the id is live (between head and tail-1 modulo NUM_CKPT).
- A non-live id SHALL be ignored entirely.
REQ-029 ROLLBACK SHALL copy arch_map into the map in one cycle.
REQ-030 WALK and IDLE-rename SHALL write every enabled port. On equal lrd, the higher-index port wins.
REQ-031 rn_wren SHALL be ignored in any cycle where restore, ROLLBACK or WALK applies.
REQ-032 Checkpoints SHALL form a circular queue with head, tail and count registers.
- alloc: writes snapshot[tail], tail+1, count+1.
- free: head+1, count-1.
- Pointers wrap modulo NUM_CKPT.
REQ-033 Snapshot content SHALL equal the map after applying the same-cycle IDLE rename writes of slots 0..ckpt_alloc_slot inclusive.
REQ-034 An alloc SHALL be dropped (no state change) if ckpt_full is 1, even with a same-cycle free, or if restore is asserted.
REQ-035 A free SHALL be ignored if count is 0 or restore is asserted.
REQ-036 Simultaneous accepted alloc and free SHALL leave count unchanged.
REQ-037 A live restore SHALL:
- set tail to restore_id+1, keeping the restored checkpoint live;
- set count to (restore_id - head + 1) mod NUM_CKPT, with result 0 treated as NUM_CKPT;
- invalidate all younger checkpoints.
REQ-038 ckpt_full SHALL equal (count == NUM_CKPT). ckpt_alloc_id SHALL equal tail.

Reset
REQ-039 On reset_n low, asynchronously:
- map[i] = i for all i;
- head = tail = count = 0, so ckpt_full = 0 and ckpt_alloc_id = 0;
- snapshot contents are don't-care.
REQ-040 Reset SHALL override any in-progress restore, rollback or walk. The first edge after release behaves as IDLE with empty checkpoints.

Verification
REQ-041 Bypass: RN_WIDTH=2, slot0 writes x5<-40, slot1 reads lrs1=5 and writes x5<-41, same cycle.
- Slot1 prs1 = 40.
- Slot0 old_prd = 5.
- Next cycle, a read of x5 returns 41.
REQ-042 Checkpoint/restore, 2-slot group:
- Group: slot0 writes x3<-33, alloc_slot=0, slot1 writes x4<-44.
- Next cycle, x3<-50 with no alloc.
- Then restore id 0.
- Required: map x3=33, x4=4; count=1; tail=1.
REQ-043 Full: allocate 4 times.
- ckpt_full=1.
- 5th alloc together with free: alloc dropped, count=3.
- Next alloc accepted with id 0 (wrap).
REQ-044 Priority: restore (live id) + ROLLBACK + rename in the same cycle.
- Map equals the snapshot.
- arch_map and rename writes are ignored.
REQ-045 Walk: two ports both with lrd=7 (prd 20, 21) → map[7]=21. Restore to a non-live id → no change anywhere.
REQ-046 Reset mid-walk with count=2 → all outputs return to reset values; map[i]=i.
